// File: rtl/step_dir_decoder.sv
// step_dir_decoder: step/direction receiver that tracks position, step period, stall and reversal.
// Defining STEP_FILTER_EN adds a FILT_LEN-clock glitch filter on the synchronised pul/dir.
module step_dir_decoder #(
  parameter int POS_W     = 32,
  parameter int PERIOD_W  = 20,
  parameter int STALL_CYC = 150000,
  parameter int FILT_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pul_in,
  input  logic                       dir_in,
  input  logic                       clr_pos,
  output logic signed [POS_W-1:0]    pos,
  output logic                       step_stb,
  output logic                       dir_out,
  output logic                       dir_chg,
  output logic [PERIOD_W-1:0]        period,
  output logic                       period_valid,
  output logic                       moving
);

  typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;

  localparam logic [PERIOD_W-1:0] STALL_LAST = PERIOD_W'(STALL_CYC - 1);

  if (FILT_LEN < 1 || STALL_CYC < 2 ||
      longint'(STALL_CYC) >= (longint'(1) << PERIOD_W)) begin : g_param_check
    $error("step_dir_decoder: parameter out of range");
  end

  logic [1:0] pul_sync_q, dir_sync_q, warm_q;
  logic       armed_q;
  logic       pul_s, dir_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pul_sync_q <= '0;
      dir_sync_q <= '0;
      warm_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      pul_sync_q <= {pul_sync_q[0], pul_in};
      dir_sync_q <= {dir_sync_q[0], dir_in};
      warm_q     <= {warm_q[0], 1'b1};
      // A pul_in already high at reset release must be seen low before it may step.
      armed_q    <= armed_q | (warm_q[1] & ~pul_sync_q[1]);
    end
  end

`ifdef STEP_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_LEN - 1);

  logic [1:0] filt_raw, filt_out;
  assign filt_raw = {dir_sync_q[1], pul_sync_q[1]};

  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic           val_q;
    logic [FCW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        val_q <= 1'b0;
        cnt_q <= '0;
      end else if (filt_raw[g] == val_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FCNT_LAST) begin
        val_q <= filt_raw[g];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + FCW'(1);
      end
    end

    assign filt_out[g] = val_q;
  end

  assign pul_s = filt_out[0];
  assign dir_s = filt_out[1];
`else
  assign pul_s = pul_sync_q[1];
  assign dir_s = dir_sync_q[1];
`endif

  state_t                   state_q, state_d;
  logic                     pul_d_q;
  logic signed [POS_W-1:0]  pos_q, pos_d;
  logic                     stb_q, dir_q, dir_d, chg_q, chg_d;
  logic [PERIOD_W-1:0]      period_q, period_d, pcnt_q, pcnt_d, pcnt_sat;
  logic                     pv_q, pv_d;
  logic                     step_edge, same_dir, stall;

  assign step_edge = pul_s & ~pul_d_q & armed_q;
  assign same_dir  = (dir_s == dir_q);
  assign pcnt_sat  = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_W'(1);
  assign stall     = (pcnt_q == STALL_LAST);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    pv_d     = pv_q;
    chg_d    = 1'b0;
    dir_d    = step_edge ? dir_s : dir_q;
    pcnt_d   = step_edge ? '0 : pcnt_sat;

    if (clr_pos)        pos_d = '0;
    else if (!step_edge) pos_d = pos_q;
    else if (dir_s)      pos_d = pos_q - POS_W'(1);
    else                 pos_d = pos_q + POS_W'(1);

    case (state_q)
      IDLE: begin
        if (step_edge) state_d = FIRST;
      end
      FIRST, RUN: begin
        if (step_edge) begin
          if (same_dir) begin
            period_d = pcnt_sat;
            pv_d     = 1'b1;
            state_d  = RUN;
          end else begin
            chg_d   = 1'b1;
            pv_d    = 1'b0;
            state_d = FIRST;
          end
        end else if (stall) begin
          state_d  = IDLE;
          pv_d     = 1'b0;
          period_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pul_d_q  <= 1'b0;
      pos_q    <= '0;
      stb_q    <= 1'b0;
      dir_q    <= 1'b0;
      chg_q    <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pul_d_q  <= pul_s;
      pos_q    <= pos_d;
      stb_q    <= step_edge;
      dir_q    <= dir_d;
      chg_q    <= chg_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign pos          = pos_q;
  assign step_stb     = stb_q;
  assign dir_out      = dir_q;
  assign dir_chg      = chg_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign moving       = (state_q != IDLE);

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: directed and random pulse trains against a timestamp-based model.
module tb_step_dir_decoder;

  localparam int POS_W    = 8;
  localparam int PERIOD_W = 10;
  localparam int STALL    = 150;
  localparam int FILT     = 4;
  localparam int SETUP    = 3;
`ifdef STEP_FILTER_EN
  localparam int LAT  = 2 + FILT;
  localparam int MINW = FILT;
`else
  localparam int LAT  = 2;
  localparam int MINW = 1;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                pul_in = 1'b0, dir_in = 1'b0, clr_pos = 1'b0;
  logic [POS_W-1:0]    pos;
  logic                step_stb, dir_out, dir_chg, period_valid, moving;
  logic [PERIOD_W-1:0] period;

  step_dir_decoder #(
    .POS_W(POS_W), .PERIOD_W(PERIOD_W), .STALL_CYC(STALL), .FILT_LEN(FILT)
  ) dut (
    .clk(clk), .rst(rst), .pul_in(pul_in), .dir_in(dir_in), .clr_pos(clr_pos),
    .pos(pos), .step_stb(step_stb), .dir_out(dir_out), .dir_chg(dir_chg),
    .period(period), .period_valid(period_valid), .moving(moving)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, n_stb = 0, n_chg = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: each driven rising edge becomes a timestamped step; outputs derive from step history.
  typedef struct { int t; logic d; } step_t;
  step_t sq[$];
  int    cyc = 0;
  int    m_last, m_nsame;
  logic [POS_W-1:0]    m_pos;
  logic [PERIOD_W-1:0] m_per;
  logic  m_stb, m_dir, m_chg, m_pv, m_mov;

  always @(posedge clk or posedge rst) begin
    step_t s;
    if (rst) begin
      sq.delete();
      m_pos = '0; m_per = '0; m_stb = 0; m_dir = 0; m_chg = 0; m_pv = 0; m_mov = 0;
      m_nsame = 0; m_last = 0;
    end else begin
      cyc++;
      m_stb = 0;
      m_chg = 0;
      if (sq.size() > 0 && sq[0].t == cyc) begin
        s = sq.pop_front();
        m_stb = 1;
        if (!m_mov) begin
          m_mov = 1; m_nsame = 1;
        end else if (s.d != m_dir) begin
          m_chg = 1; m_nsame = 1; m_pv = 0;
        end else begin
          m_nsame++;
          m_per = (cyc - m_last > 1023) ? 10'h3FF : PERIOD_W'(cyc - m_last);
          m_pv = 1;
        end
        if (!clr_pos) m_pos = s.d ? m_pos - 8'd1 : m_pos + 8'd1;
        m_dir = s.d;
        m_last = cyc;
      end else if (m_mov && (cyc - m_last >= STALL)) begin
        m_mov = 0; m_pv = 0; m_per = '0; m_nsame = 0;
      end
      if (clr_pos) m_pos = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("pos", pos, m_pos);
      check("step_stb", step_stb, m_stb);
      check("dir_out", dir_out, m_dir);
      check("dir_chg", dir_chg, m_chg);
      check("period", period, m_per);
      check("period_valid", period_valid, m_pv);
      check("moving", moving, m_mov);
      if (step_stb) n_stb++;
      if (dir_chg) n_chg++;
    end
  end

  task automatic pulse(input logic d, input int hi, input int lo);
    if (d !== dir_in) begin
      dir_in = d;
      repeat (SETUP) @(negedge clk);
    end
    pul_in = 1'b1;
    sq.push_back('{t: cyc + LAT + 1, d: d});
    repeat (hi) @(negedge clk);
    pul_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic clear_pos();
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    int base_stb, base_chg, hi, lo;
    logic d;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_pos", pos, 0);
    check("rst_stb", step_stb, 0);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_moving", moving, 0);
    repeat (4) @(negedge clk);

    // Five up steps at period 75, then three reversed steps.
    for (int i = 0; i < 5; i++) pulse(1'b0, 37, 38);
    check("up5_pos", pos, 5);
    check("up5_stb_count", n_stb, 5);
    check("up5_period", period, 75);
    check("up5_pv", period_valid, 1);
    check("up5_moving", moving, 1);
    base_chg = n_chg;
    pulse(1'b1, 37, 38);
    check("rev1_pv", period_valid, 0);
    pulse(1'b1, 37, 38);
    check("rev2_pv", period_valid, 1);
    check("rev2_period", period, 75);
    pulse(1'b1, 37, 38);
    check("rev3_pos", pos, 2);
    check("rev_chg_count", n_chg - base_chg, 1);

    repeat (STALL) @(negedge clk);
    check("stall_moving", moving, 0);
    check("stall_pv", period_valid, 0);
    check("stall_period", period, 0);
    pulse(1'b1, 37, 38);
    check("restart_moving", moving, 1);
    check("restart_pv", period_valid, 0);

    // Position wrap both ways, then clear coincident with a strobe.
    clear_pos();
    for (int i = 0; i < 127; i++) pulse(1'b0, MINW, MINW);
    settle();
    check("wrap_127", pos, 8'h7F);
    pulse(1'b0, MINW, MINW);
    settle();
    check("wrap_m128", pos, 8'h80);
    clear_pos();
    pulse(1'b1, MINW, MINW);
    settle();
    check("wrap_m1", pos, 8'hFF);
    pulse(1'b1, MINW, MINW);
    settle();
    pul_in = 1'b1;
    sq.push_back('{t: cyc + LAT + 1, d: dir_in});
    repeat (LAT) @(negedge clk);
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
    check("clr_hit_stb", step_stb, 1);
    check("clr_hit_pos", pos, 0);
    pul_in = 1'b0;
    repeat (MINW + 4) @(negedge clk);

    // Stall boundary: gap of exactly STALL keeps running, STALL+1 restarts.
    pulse(1'b0, 10, STALL - 10);
    pulse(1'b0, 10, STALL - 9);
    check("bnd_period", period, STALL);
    check("bnd_moving", moving, 1);
    pulse(1'b0, 10, 40);
    check("bnd_restart_moving", moving, 1);
    check("bnd_restart_pv", period_valid, 0);

    // Three-clock glitch: counted without filter, suppressed with it.
    base_stb = n_stb;
    pul_in = 1'b1;
`ifndef STEP_FILTER_EN
    sq.push_back('{t: cyc + LAT + 1, d: dir_in});
`endif
    repeat (3) @(negedge clk);
    pul_in = 1'b0;
    repeat (LAT + 6) @(negedge clk);
`ifdef STEP_FILTER_EN
    check("glitch_steps", n_stb - base_stb, 0);
    base_stb = n_stb;
    pulse(1'b0, FILT, FILT);
    settle();
    check("filt_pulse_steps", n_stb - base_stb, 1);
`else
    check("glitch_steps", n_stb - base_stb, 1);
`endif

    // Reset in the middle of a high phase, released while still high.
    pulse(1'b0, 20, 20);
    pul_in = 1'b1;
    sq.push_back('{t: cyc + LAT + 1, d: dir_in});
    repeat (LAT + 8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_pos", pos, 0);
    check("arst_stb", step_stb, 0);
    check("arst_dir", dir_out, 0);
    check("arst_chg", dir_chg, 0);
    check("arst_period", period, 0);
    check("arst_pv", period_valid, 0);
    check("arst_moving", moving, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base_stb = n_stb;
    repeat (LAT + 8) @(negedge clk);
    check("arst_high_nostep", n_stb - base_stb, 0);
    pul_in = 1'b0;
    repeat (MINW + 5) @(negedge clk);
    pulse(1'b0, MINW, MINW + 4);
    settle();
    check("arst_next_pos", pos, 1);

    // Random trains with reversals, clears and occasional stalls.
    for (int i = 0; i < 300; i++) begin
      d  = ($urandom_range(0, 3) == 0) ? ~dir_in : dir_in;
      hi = $urandom_range(MINW, MINW + 5);
      lo = ($urandom_range(0, 11) == 0) ? STALL - 5 + $urandom_range(0, 10)
                                         : $urandom_range(MINW, MINW + 8);
      pulse(d, hi, lo);
      if ($urandom_range(0, 7) == 0) clear_pos();
    end
    repeat (STALL + 5) @(negedge clk);
    check("final_moving", moving, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Step/direction receiver: the counterpart of the stepper pulse generator. It accepts an external `pul`/`dir` pair, resynchronises it to the local clock and counts steps into a signed position. It also measures the step period, detects stall and direction reversal. It sits on the driver/feedback side of the motor interface, e.g. monitoring generator output for closed-loop checks or receiving step commands from another board.

## Interface
- `POS_W`, 32: position width, signed two's complement.
- `PERIOD_W`, 20: period counter width.
- `STALL_CYC`, 150000: clocks without a step edge before the block declares a stall; must satisfy 2 ≤ `STALL_CYC` < 2^`PERIOD_W`.
- `FILT_LEN`, 4: glitch-filter length in clocks, ≥ 1; used only when `STEP_FILTER_EN` is defined.
- `clk` input 1: system clock.
- `rst` input 1: reset; asynchronous, active-high.
- `pul_in` input 1: asynchronous step pulse; a rising edge is one step.
- `dir_in` input 1: asynchronous direction; 0 increments, 1 decrements.
- `clr_pos` input 1: synchronous position clear, sampled each clock.
- `pos` output `POS_W`: signed step position.
- `step_stb` output 1: one-clock strobe per detected step.
- `dir_out` output 1: direction latched at the last step.
- `dir_chg` output 1: one-clock strobe when a step's direction differs from the previous step's.
- `period` output `PERIOD_W`: clocks between the last two step edges.
- `period_valid` output 1: `period` holds a measurement from the current run.
- `moving` output 1: at least one step seen and no stall since.

## Operation
- **Synchronisation.** `pul_in` and `dir_in` each pass through a 2-FF synchroniser.
- **Step detection.**
  - The pipeline registers the synchronised (optionally filtered) `pul` as `pul_d`.
  - A step edge is `pul_s & ~pul_d`.
  - `dir` is taken from the same pipeline stage, so both see identical latency.
- **On each step edge:**
  - `step_stb` = 1 for one clock.
  - `dir_out` takes the sampled `dir`.
  - `pos` += 1 when `dir` = 0, or −= 1 when `dir` = 1.
  - `pos` wraps modulo 2^`POS_W`; no saturation.
- **clr_pos.** `pos` ← 0 on the next clock. If it coincides with a step edge, the clear wins and the step is not applied to `pos`; `step_stb` still fires.
- **Period counter `pcnt`.**
  - Reset to 0 on every step edge.
  - Otherwise increments each clock, saturating at 2^`PERIOD_W`−1.
  - Measured period = `pcnt`+1, saturated.
- **State machine:**
  - IDLE: `moving` = 0, `period_valid` = 0. A step edge goes to FIRST.
  - FIRST: `moving` = 1. A step edge in the same direction loads `period`, sets `period_valid` and goes to RUN. A step edge in the reverse direction pulses `dir_chg` and stays in FIRST.
  - RUN: a step edge in the same direction updates `period`. A step edge in the reverse direction pulses `dir_chg`, clears `period_valid` and goes to FIRST; `period` holds its value.
  - FIRST/RUN: `pcnt` reaching `STALL_CYC`−1 with no edge goes to IDLE, clearing `moving`, `period_valid` and `period`.
- **Precedence.**
  - A step edge and a stall in the same cycle: the edge wins.
  - The first step after reset or after a stall never pulses `dir_chg`.
- **Reset (any time, including mid-pulse).** All outputs and all state return to reset values immediately:
  - `pos` = 0, `step_stb` = 0, `dir_out` = 0, `dir_chg` = 0, `period` = 0, `period_valid` = 0, `moving` = 0.
  - State = IDLE; synchronisers, `pul_d` and `pcnt` = 0.
  - A `pul_in` already high at reset release produces no step until it falls and rises again.

## Timing
- E0 = first clk edge sampling `pul_in` = 1.
- Without filter: sync outputs are high after E1; `step_stb`, `pos`, `dir_out` and `dir_chg` update after E2. Latency is 2 clocks, outputs registered.
- `period`, `period_valid` and state update on the same edge as `pos`.
- `dir_in` must be stable from 2 clocks before the `pul_in` rising edge until 1 clock after it.
- Maximum step rate without filter: one step every 2 clocks, high ≥ 1 clock and low ≥ 1 clock.
- Stall: IDLE is entered `STALL_CYC` clocks after the last step strobe.

## Configuration
- `STEP_FILTER_EN` defined:
  - Synchronised `pul` and `dir` each pass a filter; the filtered value changes only after the input has differed from it for `FILT_LEN` consecutive clocks.
  - Adds exactly `FILT_LEN` clocks of latency.
  - Pulses or gaps shorter than `FILT_LEN` clocks are suppressed.
- Undefined: no filter logic; every synchronised rising edge counts.

## Test plan
- Reset, `dir_in` = 0, 5 pulses of period 75000 (37500 high) → `pos` = 5, `step_stb` ×5. After the 2nd edge: `period` = 75000, `period_valid` = 1, `moving` = 1.
- From `pos` = 5, `dir_in` = 1, 3 pulses → `pos` = 2. `dir_chg` pulses on the first reversed step only; `period_valid` is 0 until the 2nd reversed step, then `period` = 75000.
- Stop pulses → exactly 150000 clocks after the last `step_stb`: `moving` = 0, `period_valid` = 0, `period` = 0. The next single pulse gives `moving` = 1, `period_valid` = 0.
- `POS_W` = 8: `pos` = 127 then 1 up-step → −128; `pos` = 0 then 1 down-step → −1. `clr_pos` coincident with `step_stb` → `pos` = 0.
- `STEP_FILTER_EN`, `FILT_LEN` = 4: a 3-clock high glitch → no `step_stb`; a 4-high/4-low pulse → exactly one step with latency 6 clocks. Without the macro, the same 3-clock glitch → one step.
- Assert `rst` mid-high-phase of `pul_in`, release while it is still high → all outputs 0 and no step until the next rising edge.
